dsp_inverse: RTL
================

# dsp_inverse

Iterative inverse of the 4-bit DSP test block. Given a DSP result `out`, the known operand `b` and the mode bit `m`, it recovers operand `a`. With `m=1` (multiply) it divides; with `m=0` (add) it subtracts. It sits downstream of the DSP in the test fabric, with a valid/ready handshake on each side. Its purpose is to check DSP results in-loop and to exercise sequential packing alongside the combinational and registered DSP variants.

## Interface
Parameters:
- `DATA_WIDTH`, 4 — width of the DSP result; operands are `DATA_WIDTH/2` bits; must be even and ≥ 2.

Ports:
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `rst_n`  input  1  — asynchronous, active-low reset.
- `in_valid`  input  1  — request valid.
- `in_ready`  output  1  — block can accept a request.
- `out_in`  input  DATA_WIDTH  — DSP result to invert.
- `b`  input  DATA_WIDTH/2  — known operand.
- `m`  input  1  — mode: 1 = multiply, 0 = add.
- `out_valid`  output  1  — result valid.
- `out_ready`  input  1  — consumer accepts result.
- `a`  output  DATA_WIDTH/2  — recovered operand.
- `ovf`  output  1  — recovered operand does not fit in DATA_WIDTH/2 bits, or a borrow occurred.
- `err`  output  1  — divide by zero (`m=1`, `b=0`).
- `rem`  output  DATA_WIDTH/2  — division remainder. Present only with `DSP_INVERSE_REM_EN`.

## Operation
- FSM states: IDLE, DIV, DONE.
- `in_ready` = (state == IDLE). Accept = `in_valid & in_ready`.
- On accept, operands are latched.
  - `m=0`: go to DONE.
    - diff = `out_in` − `b` at DATA_WIDTH+1 bits.
    - `a` = diff[DATA_WIDTH/2-1:0].
    - `ovf` = borrow, or any of diff[DATA_WIDTH-1:DATA_WIDTH/2] set.
  - `m=1`, `b=0`: go to DONE with `err=1`, `a=0`, `ovf=0`.
  - `m=1`, `b≠0`: go to DIV; load the restoring-division registers and set the step counter to DATA_WIDTH−1.
- DIV performs one restoring step per cycle, MSB first, for DATA_WIDTH cycles.
  - Partial remainder width: DATA_WIDTH/2+1 bits. Quotient width: DATA_WIDTH bits.
  - After the last step, go to DONE.
    - `a` = quotient[DATA_WIDTH/2-1:0].
    - `ovf` = |quotient[DATA_WIDTH-1:DATA_WIDTH/2].
    - `err` = 0.
- DONE: `out_valid=1`. Outputs hold stable until `out_ready`, then return to IDLE.
- No new request is accepted in the DONE cycle (no bypass).
- Reset (any state, including mid-DIV) aborts immediately. No partial result is ever presented.
- Reset values: state IDLE, `out_valid=0`, `in_ready=1`, `a=0`, `ovf=0`, `err=0`, `rem=0`, counter 0.

## Timing
- `m=0` or divide-by-zero: `out_valid` rises 1 cycle after the accept edge.
- `m=1`, `b≠0`: `out_valid` rises DATA_WIDTH+1 cycles after accept (5 at default).
- Throughput: one request per latency + 1 cycles when `out_ready` is held high.
- `a`, `ovf`, `err`, `rem` and `out_valid` are all registered; no combinational input-to-output path.
- `in_ready` is decoded from registered state only.
- `out_ready` held low leaves all outputs unchanged indefinitely. `in_valid` during DIV/DONE is ignored, not queued.

## Configuration
- `DSP_INVERSE_REM_EN` defined:
  - `rem` port exists and carries the final partial remainder (`m=1`), or 0 for `m=0` and divide-by-zero.
  - `ovf` additionally asserts when `rem≠0` in `m=1`, so the result must be an exact product.
- Not defined:
  - no `rem` port and no remainder register;
  - a non-zero remainder is silently truncated;
  - `ovf` covers only width overflow and borrow.

## Structure
- Package `dsp_inverse_pkg`:
  - state enum (IDLE/DIV/DONE);
  - mode constants MODE_ADD=1'b0, MODE_MUL=1'b1;
  - localparam helpers for operand width and counter width ($clog2(DATA_WIDTH)).
- Sub-module `dsp_inverse_divstep`: combinational single restoring-division step (shift, trial subtract, quotient bit, restore). It is instantiated once and iterated by the FSM.

## Test plan
- `m=1`, `out_in=6`, `b=2` → after 5 cycles `a=3`, `ovf=0`, `err=0`, `rem=0`.
- `m=1`, `out_in=9`, `b=2` → `a=0` (quotient 4 truncated), `ovf=1`; with REM_EN, `rem=1`.
- `m=1`, `b=0`, `out_in=5` → `out_valid` after 1 cycle, `err=1`, `a=0`, `ovf=0`.
- `m=0`, `out_in=5`, `b=2` → 1-cycle latency, `a=3`, `ovf=0`.
- `m=0`, `out_in=1`, `b=2` → `a=3`, `ovf=1` (borrow). `out_in=7`, `b=1` → `a=2`, `ovf=1`.
- Reset mid-DIV and backpressure:
  - Accept `6/2` (`m=1`), assert `rst_n=0` at cycle 2 → `out_valid=0`, `in_ready=1` after reset. A following request `6/3` then yields `a=2`.
  - With `out_ready=0` for 10 cycles, `a` is held stable and a concurrent `in_valid` is not accepted.

Source files
------------

// File: rtl/dsp_inverse_pkg.sv
// rtl/dsp_inverse_pkg.sv - shared types and width helpers for dsp_inverse
package dsp_inverse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_MUL = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 4;

    function automatic int op_width(input int dw);
        return dw / 2;
    endfunction

    function automatic int cnt_width(input int dw);
        return $clog2(dw);
    endfunction

endpackage

// File: rtl/dsp_inverse_divstep.sv
// rtl/dsp_inverse_divstep.sv - one combinational restoring-division step
module dsp_inverse_divstep #(
    parameter int OW = 2
) (
    input  logic [OW:0]   rem_i,
    input  logic          bit_i,
    input  logic [OW-1:0] divisor_i,
    output logic [OW:0]   rem_o,
    output logic          q_o
);

    logic [OW+1:0] shifted;
    logic [OW:0]   trial;

    // The incoming remainder is always below the divisor, so the difference fits in OW+1 bits.
    assign shifted = {rem_i, bit_i};
    assign q_o     = (shifted >= {2'b00, divisor_i});
    assign trial   = shifted[OW:0] - {1'b0, divisor_i};
    assign rem_o   = q_o ? trial : shifted[OW:0];

endmodule

// File: rtl/dsp_inverse.sv
// rtl/dsp_inverse.sv - iterative inverse of the DSP block (optional remainder via DSP_INVERSE_REM_EN)
module dsp_inverse
    import dsp_inverse_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   out_in,
    input  logic [DATA_WIDTH/2-1:0] b,
    input  logic                    m,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH/2-1:0] a,
    output logic                    ovf,
    output logic                    err
`ifdef DSP_INVERSE_REM_EN
    ,
    output logic [DATA_WIDTH/2-1:0] rem
`endif
);

    localparam int DW = DATA_WIDTH;
    localparam int OW = op_width(DATA_WIDTH);
    localparam int CW = cnt_width(DATA_WIDTH);

    state_e        state_q, state_d;
    logic [DW-1:0] opnd_q, opnd_d;
    logic [OW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [OW:0]   prem_q, prem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] a_q, a_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
`ifdef DSP_INVERSE_REM_EN
    logic [OW-1:0] rem_q, rem_d;
`endif

    logic          accept;
    logic [DW:0]   diff;
    logic [OW:0]   step_rem;
    logic          step_q;
    logic [DW-1:0] quot_fin;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign diff      = {1'b0, out_in} - (DW+1)'(b);

    dsp_inverse_divstep #(.OW(OW)) u_divstep (
        .rem_i     (prem_q),
        .bit_i     (opnd_q[cnt_q]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef DSP_INVERSE_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
`ifdef DSP_INVERSE_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        opnd_d   = opnd_q;
        dvs_d    = dvs_q;
        quot_d   = quot_q;
        prem_d   = prem_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
`ifdef DSP_INVERSE_REM_EN
        rem_d    = rem_q;
`endif
        // Quotient bits are deposited MSB first at the position of the current step.
        quot_fin        = quot_q;
        quot_fin[cnt_q] = step_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    opnd_d = out_in;
                    dvs_d  = b;
                    if (m == MODE_MUL) begin
                        if (b == '0) begin
                            a_d     = '0;
                            ovf_d   = 1'b0;
                            err_d   = 1'b1;
`ifdef DSP_INVERSE_REM_EN
                            rem_d   = '0;
`endif
                            state_d = DONE;
                        end else begin
                            prem_d  = '0;
                            quot_d  = '0;
                            cnt_d   = CW'(DW - 1);
                            state_d = DIV;
                        end
                    end else begin
                        a_d     = diff[OW-1:0];
                        ovf_d   = diff[DW] | (|diff[DW-1:OW]);
                        err_d   = 1'b0;
`ifdef DSP_INVERSE_REM_EN
                        rem_d   = '0;
`endif
                        state_d = DONE;
                    end
                end
            end
            DIV: begin
                quot_d = quot_fin;
                prem_d = step_rem;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    a_d     = quot_fin[OW-1:0];
                    err_d   = 1'b0;
`ifdef DSP_INVERSE_REM_EN
                    rem_d   = step_rem[OW-1:0];
                    ovf_d   = (|quot_fin[DW-1:OW]) | (|step_rem);
`else
                    ovf_d   = |quot_fin[DW-1:OW];
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign a   = a_q;
    assign ovf = ovf_q;
    assign err = err_q;
`ifdef DSP_INVERSE_REM_EN
    assign rem = rem_q;
`endif

endmodule
